// File: rtl/vga_pkg.sv
// Shared types and default 800x600 raster timing for the VGA timing generator.
package vga_pkg;

   // Signed raster coordinate: negative in blanking, 0..ACTIVE-1 when visible.
   typedef logic signed [10:0] coord_t;

   // Default horizontal timing (pixels).
   localparam int H_ACTIVE_DEF = 800;
   localparam int H_FP_DEF     = 56;
   localparam int H_SYNC_DEF   = 120;
   localparam int H_BP_DEF     = 64;

   // Default vertical timing (lines).
   localparam int V_ACTIVE_DEF = 600;
   localparam int V_FP_DEF     = 37;
   localparam int V_SYNC_DEF   = 6;
   localparam int V_BP_DEF     = 23;

   // Sync polarity constants.
   localparam logic POL_HIGH = 1'b1;
   localparam logic POL_LOW  = 1'b0;

   // True when lo <= v <= hi (all signed).
   function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
      return (v >= lo) && (v <= hi);
   endfunction

   // Drive the active polarity while inside the sync window, idle level otherwise.
   function automatic logic sync_level(logic active, logic pol);
      return active ? pol : ~pol;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Signed up-counter for one raster axis: runs MIN..MAX, wraps to MIN by compare.
// Exposes the next-state value so the top can register decodes in step with it.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter coord_t MIN = -11'sd240,
   parameter coord_t MAX = 11'sd799
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   output logic signed [10:0] count,
   output logic signed [10:0] count_next,
   output logic               tc
);

   assign tc = (count == MAX);

   // Next value: hold when idle, wrap on terminal count; the +1 never runs past MAX.
   always_comb begin
      count_next = count;
      if (en) begin
         if (tc) begin
            count_next = MIN;
         end else begin
            count_next = count + 11'sd1;
         end
      end
   end

   // Count register, async reset to the start of blanking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= MIN;
      end else begin
         count <= count_next;
      end
   end

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: signed pixel coordinates plus hsync/vsync/de and
// line/frame start pulses, all registered and aligned to the same clock edge.
module vga_timing
   import vga_pkg::*;
#(
   parameter int   HACTIVE = H_ACTIVE_DEF,
   parameter int   HFP     = H_FP_DEF,
   parameter int   HSYNC   = H_SYNC_DEF,
   parameter int   HBP     = H_BP_DEF,
   parameter int   VACTIVE = V_ACTIVE_DEF,
   parameter int   VFP     = V_FP_DEF,
   parameter int   VSYNC   = V_SYNC_DEF,
   parameter int   VBP     = V_BP_DEF,
   parameter logic HS_POL  = POL_HIGH,
   parameter logic VS_POL  = POL_HIGH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pix_en,
   output logic signed [10:0] spotX,
   output logic signed [10:0] spotY,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic               line_start,
   output logic               frame_start
);

   localparam coord_t H_MIN   = coord_t'(-(HFP + HSYNC + HBP));
   localparam coord_t H_MAX   = coord_t'(HACTIVE - 1);
   localparam coord_t HS_LO   = coord_t'(-(HSYNC + HBP));
   localparam coord_t HS_HI   = coord_t'(-HBP - 1);
   localparam coord_t V_MIN   = coord_t'(-(VFP + VSYNC + VBP));
   localparam coord_t V_MAX   = coord_t'(VACTIVE - 1);
   localparam coord_t VS_LO   = coord_t'(-(VSYNC + VBP));
   localparam coord_t VS_HI   = coord_t'(-VBP - 1);
   localparam coord_t ZERO    = '0;

   logic signed [10:0] x_cur;
   logic signed [10:0] x_next;
   logic signed [10:0] y_cur;
   logic signed [10:0] y_next;
   logic               h_tc;
   logic               v_en;
   logic               v_tc_unused;

   logic               hsync_d;
   logic               vsync_d;
   logic               de_d;
   logic               line_d;
   logic               frame_d;

   // Lines advance only on the pixel edge that wraps the horizontal counter.
   assign v_en = pix_en & h_tc;

   vga_axis_counter #(
      .MIN (H_MIN),
      .MAX (H_MAX)
   ) u_h (
      .clk        (clk),
      .rst        (rst),
      .en         (pix_en),
      .count      (x_cur),
      .count_next (x_next),
      .tc         (h_tc)
   );

   // Frame wrap falls out of v_en, so the vertical terminal count has no consumer.
   vga_axis_counter #(
      .MIN (V_MIN),
      .MAX (V_MAX)
   ) u_v (
      .clk        (clk),
      .rst        (rst),
      .en         (v_en),
      .count      (y_cur),
      .count_next (y_next),
      .tc         (v_tc_unused)
   );

   assign spotX = x_cur;
   assign spotY = y_cur;

   // Decode the coordinate about to be loaded so the registered flags line up with it.
   always_comb begin
      hsync_d = sync_level(in_window(x_next, HS_LO, HS_HI), HS_POL);
      vsync_d = sync_level(in_window(y_next, VS_LO, VS_HI), VS_POL);
      de_d    = !x_next[10] && !y_next[10];
      line_d  = (x_next == ZERO) && !y_next[10];
      frame_d = (x_next == ZERO) && (y_next == ZERO);
   end

   // Output register: levels hold while idle, pulses only follow a pixel edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         de          <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (pix_en) begin
         hsync       <= hsync_d;
         vsync       <= vsync_d;
         de          <= de_d;
         line_start  <= line_d;
         frame_start <= frame_d;
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end
   end

endmodule
